// File: rtl/jog_pkg.sv
// Shared definitions for the jog angle controller: axis FSM states, default timing, saturating step.
package jog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } axis_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYC     = 250000;
    localparam int unsigned DEF_REPEAT_DELAY_CYC = 12500000;
    localparam int unsigned DEF_REPEAT_RATE_CYC  = 2500000;
    localparam logic [3:0]  DEF_ANGLE_MAX        = 4'd15;
    localparam logic [3:0]  DEF_ANGLE_RST        = 4'd8;

    // Next angle code: one step up or down, computed in 5 bits and held at 0 / max_code.
    function automatic logic [3:0] sat_step(input logic [3:0] angle,
                                            input logic       step,
                                            input logic       inc,
                                            input logic [3:0] max_code);
        logic [4:0] wide;
        logic [3:0] result;
        result = angle;
        if (step) begin
            if (inc) begin
                wide = {1'b0, angle} + 5'd1;
                if (wide <= {1'b0, max_code}) result = wide[3:0];
            end else begin
                wide = {1'b0, angle} - 5'd1;
                if (!wide[4]) result = wide[3:0];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jog_debounce.sv
// Two-flop synchroniser plus stability counter for one raw switch input.
module jog_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only advances while the synchronised level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/jog_angle_ctrl.sv
// Manual-jog front end: debounced direction switches step saturating 4-bit x/y angle codes.
// Auto-repeat (DELAY/REPEAT states) is built only when JOG_AUTOREPEAT_EN is defined.
module jog_angle_ctrl
    import jog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter logic [3:0]  ANGLE_MAX        = DEF_ANGLE_MAX,
    parameter logic [3:0]  ANGLE_RST        = DEF_ANGLE_RST
) (
    input  logic       i_Clk,
    input  logic       clr,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic [3:0] x_angle,
    output logic [3:0] y_angle,
    output logic       o_step,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [3:0] o_at_limit,
    output logic [1:0] x_state_o,
    output logic [1:0] y_state_o
);

    if (DEBOUNCE_CYC == 0 || REPEAT_RATE_CYC == 0 || REPEAT_RATE_CYC > REPEAT_DELAY_CYC ||
        ANGLE_RST > ANGLE_MAX) begin : g_bad_cfg
        $error("jog_angle_ctrl: inconsistent timing or angle parameters");
    end

    logic [3:0]  raw;
    logic [3:0]  db;
    logic [1:0]  inc_req;
    logic [1:0]  dec_req;
    logic [1:0]  changed;
    logic [3:0]  angle_a [2];
    axis_state_e state_a [2];
    logic        step_q;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar i = 0; i < 4; i++) begin : g_db
        jog_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk_i    (i_Clk),
            .rst_i    (clr),
            .raw_i    (raw[i]),
            .stable_o (db[i])
        );
    end

    // Axis 0 is x (switch 2 up, switch 1 down); axis 1 is y (switch 3 up, switch 4 down).
    assign inc_req = {db[2], db[1]};
    assign dec_req = {db[3], db[0]};

    for (genvar ax = 0; ax < 2; ax++) begin : g_axis
        axis_state_e state_q;
        axis_state_e state_d;
        logic        dir_q;
        logic        dir_d;
        logic        inc_now;
        logic        dec_now;
        logic        same_req;
        logic        step;
        logic        step_inc;
        logic [3:0]  angle_q;
        logic [3:0]  angle_d;

        assign inc_now  = inc_req[ax] & ~dec_req[ax];
        assign dec_now  = dec_req[ax] & ~inc_req[ax];
        assign same_req = dir_q ? inc_now : dec_now;

`ifdef JOG_AUTOREPEAT_EN
        localparam int unsigned CNT_W = $clog2(REPEAT_DELAY_CYC + 1);
        localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
        localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYC - 1);

        logic [CNT_W-1:0] rpt_q;
        logic [CNT_W-1:0] rpt_d;

        always_ff @(posedge i_Clk) begin
            if (clr) begin
                state_q <= ST_IDLE;
                dir_q   <= 1'b0;
                rpt_q   <= '0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                rpt_q   <= rpt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            rpt_d   = rpt_q;
            case (state_q)
                ST_IDLE: begin
                    if (inc_now || dec_now) begin
                        state_d = ST_DELAY;
                        dir_d   = inc_now;
                        rpt_d   = '0;
                    end
                end
                ST_DELAY: begin
                    if (!same_req) begin
                        state_d = ST_IDLE;
                    end else if (rpt_q == DELAY_LAST) begin
                        state_d = ST_REPEAT;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!same_req) begin
                        state_d = ST_IDLE;
                    end else if (rpt_q == RATE_LAST) begin
                        rpt_d = '0;
                    end else begin
                        rpt_d = rpt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            step     = 1'b0;
            step_inc = dir_q;
            case (state_q)
                ST_IDLE: begin
                    step     = inc_now | dec_now;
                    step_inc = inc_now;
                end
                ST_DELAY:  step = same_req && (rpt_q == DELAY_LAST);
                ST_REPEAT: step = same_req && (rpt_q == RATE_LAST);
                default:   step = 1'b0;
            endcase
        end
`else
        always_ff @(posedge i_Clk) begin
            if (clr) begin
                state_q <= ST_IDLE;
                dir_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
            end
        end

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            case (state_q)
                ST_IDLE: begin
                    if (inc_now || dec_now) begin
                        state_d = ST_HELD;
                        dir_d   = inc_now;
                    end
                end
                ST_HELD: begin
                    if (!same_req) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            step     = 1'b0;
            step_inc = dir_q;
            if (state_q == ST_IDLE) begin
                step     = inc_now | dec_now;
                step_inc = inc_now;
            end
        end
`endif

        // A step that would leave [0, ANGLE_MAX] leaves the angle alone and reports no change.
        assign angle_d = sat_step(angle_q, step, step_inc, ANGLE_MAX);

        always_ff @(posedge i_Clk) begin
            if (clr) begin
                angle_q <= ANGLE_RST;
            end else begin
                angle_q <= angle_d;
            end
        end

        assign changed[ax] = (angle_d != angle_q);
        assign angle_a[ax] = angle_q;
        assign state_a[ax] = state_q;
    end

    always_ff @(posedge i_Clk) begin
        if (clr) begin
            step_q <= 1'b0;
        end else begin
            step_q <= |changed;
        end
    end

    assign x_angle    = angle_a[0];
    assign y_angle    = angle_a[1];
    assign o_step     = step_q;
    assign o_LED_1    = db[0];
    assign o_LED_2    = db[1];
    assign o_LED_3    = db[2];
    assign o_LED_4    = db[3];
    assign o_at_limit = {angle_a[1] == ANGLE_MAX, angle_a[1] == 4'd0,
                         angle_a[0] == ANGLE_MAX, angle_a[0] == 4'd0};
    assign x_state_o  = state_a[0];
    assign y_state_o  = state_a[1];

endmodule

// File: tb/tb_jog_angle_ctrl.sv
// Bench for jog_angle_ctrl: directed scenarios plus random switch activity against a hold-time model.
`timescale 1ns/1ps
module tb_jog_angle_ctrl;
    import jog_pkg::*;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int LAT = 2 + DB + 1;
`ifdef JOG_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       i_Clk = 1'b0;
    logic       clr   = 1'b1;
    logic [3:0] sw    = '0;
    logic [3:0] x_angle, y_angle, o_at_limit;
    logic       o_step, o_LED_1, o_LED_2, o_LED_3, o_LED_4;
    logic [1:0] x_state_o, y_state_o;

    jog_angle_ctrl #(
        .DEBOUNCE_CYC     (DB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR)
    ) dut (
        .i_Clk      (i_Clk),
        .clr        (clr),
        .i_Switch_1 (sw[0]),
        .i_Switch_2 (sw[1]),
        .i_Switch_3 (sw[2]),
        .i_Switch_4 (sw[3]),
        .x_angle    (x_angle),
        .y_angle    (y_angle),
        .o_step     (o_step),
        .o_LED_1    (o_LED_1),
        .o_LED_2    (o_LED_2),
        .o_LED_3    (o_LED_3),
        .o_LED_4    (o_LED_4),
        .o_at_limit (o_at_limit),
        .x_state_o  (x_state_o),
        .y_state_o  (y_state_o)
    );

    always #5 i_Clk = ~i_Clk;

    int checks   = 0;
    int failures = 0;
    int step_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: raw sample history per switch, hold age per axis.
    bit hist [4][$];
    bit stable_m [4];
    int ang_m [2];
    bit act_m [2];
    int held_m [2];
    int age_m [2];
    bit step_m;

    function automatic int req_of(input int ax);
        bit up, dn;
        up = (ax == 0) ? stable_m[1] : stable_m[2];
        dn = (ax == 0) ? stable_m[0] : stable_m[3];
        if (up && !dn) return 1;
        if (dn && !up) return -1;
        return 0;
    endfunction

    task automatic model_edge();
        if (clr) begin
            for (int s = 0; s < 4; s++) begin
                hist[s].delete();
                repeat (6) hist[s].push_back(1'b0);
                stable_m[s] = 1'b0;
            end
            for (int a = 0; a < 2; a++) begin
                ang_m[a] = 8; act_m[a] = 1'b0; held_m[a] = 0; age_m[a] = 0;
            end
            step_m = 1'b0;
        end else begin
            bit moved;
            moved = 1'b0;
            for (int a = 0; a < 2; a++) begin
                int r;
                bit st;
                r  = req_of(a);
                st = 1'b0;
                if (act_m[a]) begin
                    if (r == held_m[a]) begin
                        age_m[a]++;
                        if (AR && age_m[a] >= RD && ((age_m[a] - RD) % RR) == 0) st = 1'b1;
                    end else begin
                        act_m[a] = 1'b0;
                    end
                end else if (r != 0) begin
                    act_m[a] = 1'b1; held_m[a] = r; age_m[a] = 0; st = 1'b1;
                end
                if (st) begin
                    int n;
                    n = ang_m[a] + held_m[a];
                    if (n >= 0 && n <= 15) begin
                        ang_m[a] = n;
                        moved = 1'b1;
                    end
                end
            end
            step_m = moved;
            // Accept a new level once the synchronised input has shown it for DB edges in a row.
            for (int s = 0; s < 4; s++) begin
                int n;
                bit all_new;
                hist[s].push_back(sw[s]);
                n = hist[s].size();
                all_new = 1'b1;
                for (int k = 3; k < 3 + DB; k++) begin
                    if (hist[s][n-k] == stable_m[s]) all_new = 1'b0;
                end
                if (all_new) stable_m[s] = !stable_m[s];
                while (hist[s].size() > 8) void'(hist[s].pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        model_edge();
        #1;
        if (o_step === 1'b1) step_cnt++;
        check("x_angle", x_angle, ang_m[0]);
        check("y_angle", y_angle, ang_m[1]);
        check("o_step", o_step, step_m);
        check("leds", {o_LED_4, o_LED_3, o_LED_2, o_LED_1},
              {stable_m[3], stable_m[2], stable_m[1], stable_m[0]});
        check("at_limit", o_at_limit,
              {ang_m[1] == 15, ang_m[1] == 0, ang_m[0] == 15, ang_m[0] == 0});
        check("x_idle", x_state_o == ST_IDLE, !act_m[0]);
        check("y_idle", y_state_o == ST_IDLE, !act_m[1]);
    endtask

    initial begin
        int first;

        // Reset
        clr = 1'b1; sw = '0;
        tick(); tick();
        check("rst_x", x_angle, 8);
        check("rst_y", y_angle, 8);
        check("rst_step", o_step, 0);
        check("rst_led", {o_LED_4, o_LED_3, o_LED_2, o_LED_1}, 0);
        check("rst_lim", o_at_limit, 0);
        clr = 1'b0;

        // Bounce on switch 2
        step_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            sw[1] = ~sw[1];
            repeat (2) tick();
        end
        sw[1] = 1'b0;
        repeat (10) tick();
        check("bounce_steps", step_cnt, 0);
        check("bounce_x", x_angle, 8);

        // Single press
        step_cnt = 0; first = -1;
        sw[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (first < 0 && x_angle == 4'd9) first = i;
        end
        sw[1] = 1'b0;
        repeat (10) tick();
        check("press_lat", first, LAT);
        check("press_steps", step_cnt, 1);
        check("press_x", x_angle, 9);

        // Long hold on switch 3
        step_cnt = 0;
        sw[2] = 1'b1;
        repeat (60) tick();
        check("hold_y", y_angle, AR ? 15 : 9);
        check("hold_ymax", o_at_limit[3], AR ? 1 : 0);
        check("hold_steps", step_cnt, AR ? 7 : 1);
        sw[2] = 1'b0;
        repeat (10) tick();

        // Drive x to 0 with repeated presses, then hold at the limit, then conflict
        for (int p = 0; p < 12; p++) begin
            sw[0] = 1'b1; repeat (12) tick();
            sw[0] = 1'b0; repeat (8) tick();
        end
        check("sat_x", x_angle, 0);
        check("sat_xmin", o_at_limit[0], 1);
        step_cnt = 0;
        sw[0] = 1'b1;
        repeat (40) tick();
        check("sat_steps", step_cnt, 0);
        check("sat_x_hold", x_angle, 0);
        sw[1] = 1'b1;
        repeat (12) tick();
        check("conf_x", x_angle, 0);
        check("conf_idle", x_state_o, ST_IDLE);
        sw = '0;
        repeat (10) tick();

        // Reset while switch 4 is held
        sw[3] = 1'b1;
        repeat (40) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid_rst_y", y_angle, 8);
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (first < 0 && y_angle == 4'd7) first = i;
        end
        check("mid_rst_lat", first, LAT);
        sw = '0;
        repeat (10) tick();

        // Random activity
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
            end
            sw = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 40)) tick();
        end
        sw = '0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
